serial_addsub: RTL and testbench
================================

SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 SHALL provide parameter: WIDTH, 8, operand/result width in bits; legal range 2..32.
REQ-002 SHALL provide port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL provide port: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL provide port: start  input  1  request to begin one operation; sampled each cycle.
REQ-005 SHALL provide port: sub  input  1  mode, 0 = A+B, 1 = A-B; sampled with start.
REQ-006 SHALL provide port: a  input  WIDTH  operand A; sampled with start.
REQ-007 SHALL provide port: b  input  WIDTH  operand B; sampled with start.
REQ-008 SHALL provide port: ready  output  1  high in IDLE only; start accepted only when high.
REQ-009 SHALL provide port: busy  output  1  high in RUN only.
REQ-010 SHALL provide port: done  output  1  single-cycle pulse; result valid.
REQ-011 SHALL provide port: result  output  WIDTH  sum/difference, LSB-first serially assembled.
REQ-012 SHALL provide port: carry_o  output  1  add: carry out; sub: borrow (= inverted internal carry).
REQ-013 SHALL provide port: ovf_o  output  1  two's-complement signed overflow.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 IDLE -> RUN on start=1; latch a, b XOR {WIDTH{sub}}, carry register = sub, bit counter = 0, mode = sub.
REQ-016 RUN, each cycle: sum bit = a_sh[0] ^ b_sh[0] ^ c; c <= majority(a_sh[0], b_sh[0], c); sum bit shifted into result register at MSB, result shifted right; a_sh, b_sh shifted right; counter +1.
REQ-017 RUN -> DONE after exactly WIDTH shift cycles (counter = WIDTH-1 on last shift cycle).
REQ-018 On final shift, SHALL capture carry_o = c_next XOR mode; ovf_o = carry into MSB XOR carry out of MSB.
REQ-019 DONE -> IDLE unconditionally after one cycle; done = 1 only in DONE.
REQ-020 Latency: start sampled in cycle t -> done high in cycle t+WIDTH+1; ready high again in cycle t+WIDTH+2.
REQ-021 start while busy or done SHALL be ignored (no operand latch, no state change).
REQ-022 result, carry_o, ovf_o SHALL hold their last values from DONE until the next accepted start; intermediate result bits are visible during RUN but are not valid.
REQ-023 Result arithmetic modulo 2^WIDTH; a, b, sub changes after acceptance SHALL have no effect on the running operation.

Reset
REQ-024 rst=1 at a rising edge SHALL force state IDLE, result = 0, carry_o = 0, ovf_o = 0, done = 0, busy = 0, ready = 1, counter = 0, internal carry = 0.
REQ-025 rst SHALL take priority over start and abort any operation in RUN or DONE without emitting done.

Structure
REQ-026 Package serial_addsub_pkg SHALL hold the state typedef (IDLE/RUN/DONE) and mode constants MODE_ADD = 0, MODE_SUB = 1.
REQ-027 Counter width SHALL be $clog2(WIDTH) minimum 1.
REQ-028 One sub-module serial_fa_cell (1-bit full adder plus carry flop with synchronous load/clear) SHALL be instantiated; datapath shift registers stay in the top module.

Verification (WIDTH = 8)
REQ-029 Add: a=0xC8, b=0x64, sub=0 -> done 9 cycles after start; result=0x2C, carry_o=1, ovf_o=0.
REQ-030 Sub: a=0x05, b=0x07, sub=1 -> result=0xFE, carry_o=1 (borrow), ovf_o=0.
REQ-031 Signed overflow: a=0x7F, b=0x01, sub=0 -> result=0x80, carry_o=0, ovf_o=1; a=0x80, b=0x01, sub=1 -> result=0x7F, ovf_o=1.
REQ-032 start held high through a whole operation with new operands -> only the first operation runs; the second start is accepted in the first IDLE cycle after done; ready/busy/done timing exactly per REQ-020.
REQ-033 rst asserted at 4th RUN cycle -> next cycle ready=1, result=0, carry_o=0, no done pulse; following operation 0x01+0x01 -> result=0x02.
REQ-034 Parameter sweep WIDTH = 2, 16, 32 with random operands vs. reference model: result, carry_o, ovf_o match; done at t+WIDTH+1.

Source files
------------

// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_fa_cell.sv
// One-bit full adder with its carry flop; the carry can be preset at the start
// of an operation and then advances once per enabled cycle.
module serial_fa_cell (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic load_val,
   input  logic en,
   input  logic a,
   input  logic b,
   output logic sum,
   output logic carry,
   output logic carry_next
);

   assign sum        = a ^ b ^ carry;
   assign carry_next = (a & b) | (a & carry) | (b & carry);

   always_ff @(posedge clk) begin
      if (rst)
         carry <= 1'b0;
      else if (load)
         carry <= load_val;
      else if (en)
         carry <= carry_next;
   end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial two's-complement adder/subtractor: one result bit per cycle, LSB
// first, with carry/borrow and signed-overflow flags captured on the last bit.
module serial_addsub
   import serial_addsub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry_o,
   output logic             ovf_o
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res_sh;
   logic [CW-1:0]    cnt;
   logic             mode;
   logic             accept;
   logic             last;
   logic             sum_bit;
   logic             c_cur;
   logic             c_next;

   assign accept = (state == IDLE) && start;
   assign last   = (state == RUN) && (cnt == CW'(WIDTH - 1));

   assign ready  = (state == IDLE);
   assign busy   = (state == RUN);
   assign done   = (state == DONE);
   assign result = res_sh;

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (last)  state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Subtraction is A + ~B + 1: B is inverted at load and the carry preset to 1.
   serial_fa_cell u_fa (
      .clk        (clk),
      .rst        (rst),
      .load       (accept),
      .load_val   (sub),
      .en         (state == RUN),
      .a          (a_sh[0]),
      .b          (b_sh[0]),
      .sum        (sum_bit),
      .carry      (c_cur),
      .carry_next (c_next)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh    <= '0;
         b_sh    <= '0;
         res_sh  <= '0;
         cnt     <= '0;
         mode    <= MODE_ADD;
         carry_o <= 1'b0;
         ovf_o   <= 1'b0;
      end else if (accept) begin
         a_sh <= a;
         b_sh <= (sub == MODE_SUB) ? ~b : b;
         cnt  <= '0;
         mode <= sub;
      end else if (state == RUN) begin
         res_sh <= {sum_bit, res_sh[WIDTH-1:1]};
         a_sh   <= a_sh >> 1;
         b_sh   <= b_sh >> 1;
         cnt    <= cnt + CW'(1);
         // On the MSB, c_cur is the carry into it and c_next the carry out.
         if (last) begin
            carry_o <= c_next ^ (mode == MODE_SUB);
            ovf_o   <= c_cur ^ c_next;
         end
      end
   end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed and table-driven checks of serial_addsub at WIDTH=8, plus a
// reference-model sweep over WIDTH=2/16/32 instances.
module tb_serial_addsub;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         ready;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         carry_o;
   logic         ovf_o;

   logic [2:0]   sw_start;
   logic [31:0]  sw_a;
   logic [31:0]  sw_b;
   logic         sw_sub;
   logic         rdy2, bsy2, dn2, c2, o2;
   logic         rdy16, bsy16, dn16, c16, o16;
   logic         rdy32, bsy32, dn32, c32, o32;
   logic [1:0]   r2;
   logic [15:0]  r16;
   logic [31:0]  r32;

   int tests_run    = 0;
   int tests_failed = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       sub;
      logic [7:0] res;
      logic       c;
      logic       ovf;
   } vec_t;

   vec_t vecs[11];

   always #5 clk = ~clk;

   serial_addsub #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
      .ready(ready), .busy(busy), .done(done), .result(result),
      .carry_o(carry_o), .ovf_o(ovf_o)
   );

   serial_addsub #(.WIDTH(2)) dut2 (
      .clk(clk), .rst(rst), .start(sw_start[0]), .sub(sw_sub), .a(sw_a[1:0]), .b(sw_b[1:0]),
      .ready(rdy2), .busy(bsy2), .done(dn2), .result(r2), .carry_o(c2), .ovf_o(o2)
   );

   serial_addsub #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .start(sw_start[1]), .sub(sw_sub), .a(sw_a[15:0]), .b(sw_b[15:0]),
      .ready(rdy16), .busy(bsy16), .done(dn16), .result(r16), .carry_o(c16), .ovf_o(o16)
   );

   serial_addsub #(.WIDTH(32)) dut32 (
      .clk(clk), .rst(rst), .start(sw_start[2]), .sub(sw_sub), .a(sw_a), .b(sw_b),
      .ready(rdy32), .busy(bsy32), .done(dn32), .result(r32), .carry_o(c32), .ovf_o(o32)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Pulses start for one cycle and returns the cycle (counted from the
   // accepting cycle) in which done is seen, or -1 on timeout.
   task automatic applyStimulus(input logic [7:0] ta, input logic [7:0] tb, input logic tsub,
                                output int lat);
      @(negedge clk);
      a     = ta;
      b     = tb;
      sub   = tsub;
      start = 1'b1;
      lat   = -1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (done) begin
            lat = c;
            break;
         end
      end
   endtask

   function automatic void refModel(input int w, input logic [31:0] x, input logic [31:0] y,
                                    input logic s, output logic [31:0] r,
                                    output logic c, output logic o);
      logic [63:0] mask, xm, ym, full;
      logic        sa, sb, sr;
      mask = (64'd1 << w) - 64'd1;
      xm   = {32'd0, x} & mask;
      ym   = {32'd0, y} & mask;
      if (s) begin
         full = xm - ym;
         c    = (xm < ym);
      end else begin
         full = xm + ym;
         c    = full[w];
      end
      r  = full[31:0] & mask[31:0];
      sa = xm[w-1];
      sb = ym[w-1];
      sr = full[w-1];
      o  = s ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
   endfunction

   function automatic logic sweepDone(input int idx);
      case (idx)
         0:       return dn2;
         1:       return dn16;
         default: return dn32;
      endcase
   endfunction

   task automatic sweepOne(input int idx, input int w, input logic [31:0] xa,
                           input logic [31:0] xb, input logic xs);
      logic [31:0] er, ar;
      logic        ec, eo, ac, ao;
      int          lat;
      refModel(w, xa, xb, xs, er, ec, eo);
      @(negedge clk);
      sw_a = xa;
      sw_b = xb;
      sw_sub = xs;
      sw_start[idx] = 1'b1;
      lat = -1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         sw_start = 3'b000;
         if (sweepDone(idx)) begin
            lat = c;
            break;
         end
      end
      case (idx)
         0:       begin ar = {30'd0, r2};  ac = c2;  ao = o2;  end
         1:       begin ar = {16'd0, r16}; ac = c16; ao = o16; end
         default: begin ar = r32;          ac = c32; ao = o32; end
      endcase
      checkOutput($sformatf("w%0d_latency", w), lat, w + 1);
      checkOutput($sformatf("w%0d_result", w), ar, er);
      checkOutput($sformatf("w%0d_carry", w), {31'd0, ac}, {31'd0, ec});
      checkOutput($sformatf("w%0d_ovf", w), {31'd0, ao}, {31'd0, eo});
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int lat;
      logic seen_done;
      int widths[3];
      widths = '{2, 16, 32};

      rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
      sw_start = 3'b000; sw_a = '0; sw_b = '0; sw_sub = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("reset_ready", {31'd0, ready}, 32'd1);
      checkOutput("reset_busy", {31'd0, busy}, 32'd0);
      checkOutput("reset_done", {31'd0, done}, 32'd0);
      checkOutput("reset_result", {24'd0, result}, 32'd0);
      checkOutput("reset_carry", {31'd0, carry_o}, 32'd0);
      checkOutput("reset_ovf", {31'd0, ovf_o}, 32'd0);
      rst = 1'b0;

      vecs[0]  = '{8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1, 1'b0};
      vecs[1]  = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b1, 1'b0};
      vecs[2]  = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
      vecs[3]  = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b0, 1'b1};
      vecs[4]  = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
      vecs[5]  = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0};
      vecs[6]  = '{8'h00, 8'h01, 1'b1, 8'hFF, 1'b1, 1'b0};
      vecs[7]  = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
      vecs[8]  = '{8'h7F, 8'hFF, 1'b1, 8'h80, 1'b1, 1'b1};
      vecs[9]  = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 1'b0};
      vecs[10] = '{8'h3C, 8'h3C, 1'b1, 8'h00, 1'b0, 1'b0};

      for (int i = 0; i < 11; i++) begin
         applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sub, lat);
         checkOutput($sformatf("vec%0d_latency", i), lat, W + 1);
         checkOutput($sformatf("vec%0d_result", i), {24'd0, result}, {24'd0, vecs[i].res});
         checkOutput($sformatf("vec%0d_carry", i), {31'd0, carry_o}, {31'd0, vecs[i].c});
         checkOutput($sformatf("vec%0d_ovf", i), {31'd0, ovf_o}, {31'd0, vecs[i].ovf});
      end

      // start held high: operands change mid-run, second op accepted right after done
      @(negedge clk);
      a = 8'h01; b = 8'h02; sub = 1'b0; start = 1'b1;
      for (int c = 1; c <= W + 1; c++) begin
         @(negedge clk);
         if (c == 2) begin
            a = 8'hF0;
            b = 8'h20;
         end
         checkOutput($sformatf("hold_busy_c%0d", c), {31'd0, busy}, {31'd0, (c <= W)});
         checkOutput($sformatf("hold_ready_c%0d", c), {31'd0, ready}, 32'd0);
         checkOutput($sformatf("hold_done_c%0d", c), {31'd0, done}, {31'd0, (c == W + 1)});
      end
      checkOutput("hold_first_result", {24'd0, result}, 32'h03);
      checkOutput("hold_first_carry", {31'd0, carry_o}, 32'd0);
      @(negedge clk);
      checkOutput("hold_idle_ready", {31'd0, ready}, 32'd1);
      checkOutput("hold_idle_busy", {31'd0, busy}, 32'd0);
      checkOutput("hold_idle_done", {31'd0, done}, 32'd0);
      checkOutput("hold_result_kept", {24'd0, result}, 32'h03);
      @(negedge clk);
      checkOutput("hold_second_busy", {31'd0, busy}, 32'd1);
      start = 1'b0;
      lat = -1;
      for (int c = W + 4; c <= 60; c++) begin
         @(negedge clk);
         if (done) begin
            lat = c;
            break;
         end
      end
      checkOutput("hold_second_latency", lat, 2 * W + 3);
      checkOutput("hold_second_result", {24'd0, result}, 32'h10);
      checkOutput("hold_second_carry", {31'd0, carry_o}, 32'd1);
      checkOutput("hold_second_ovf", {31'd0, ovf_o}, 32'd0);

      // reset in the 4th RUN cycle aborts the operation without a done pulse
      @(negedge clk);
      a = 8'h12; b = 8'h34; sub = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("abort_ready", {31'd0, ready}, 32'd1);
      checkOutput("abort_busy", {31'd0, busy}, 32'd0);
      checkOutput("abort_result", {24'd0, result}, 32'd0);
      checkOutput("abort_carry", {31'd0, carry_o}, 32'd0);
      seen_done = done;
      for (int c = 0; c < W + 4; c++) begin
         @(negedge clk);
         seen_done = seen_done | done;
      end
      checkOutput("abort_no_done", {31'd0, seen_done}, 32'd0);
      applyStimulus(8'h01, 8'h01, 1'b0, lat);
      checkOutput("after_abort_latency", lat, W + 1);
      checkOutput("after_abort_result", {24'd0, result}, 32'h02);

      for (int k = 0; k < 3; k++) begin
         sweepOne(k, widths[k], 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
         sweepOne(k, widths[k], 32'h0000_0000, 32'h0000_0001, 1'b1);
         for (int n = 0; n < 5; n++)
            sweepOne(k, widths[k], $urandom, $urandom, 1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
